lcd_segment_scanout: RTL and testbench

// - Owns display segment RAM (0xE00-0xE4F lower, 0xE80-0xECF upper) as the CPU memory-bus target.
// - On request, reads that RAM back out as a pixel/icon stream with valid/ready handshake to the video frame buffer.
// - Sits beside the 6S46 RAM/I/O decoder: CPU writes segments, this block is their reader.

---
 rtl/lcd_pkg.sv | 40 ++++
 rtl/lcd_segment_ram.sv | 55 +++++
 rtl/lcd_segment_scanout.sv | 165 ++++++++++++++++
 tb/tb_lcd_segment_scanout.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD segment RAM and its frame scanout.
package lcd_pkg;

    // LCD geometry
    localparam int X_PIXELS   = 32;
    localparam int Y_PIXELS   = 16;
    localparam int ICON_COUNT = 8;

    // Icon i lives in bit 0 of lower-segment nibble ICON_BASE + i
    localparam logic [6:0] ICON_BASE = 7'h40;

    // CPU-visible segment windows
    localparam logic [11:0] LCD_LOWER_BASE  = 12'hE00;
    localparam logic [11:0] LCD_UPPER_BASE  = 12'hE80;
    localparam int          LCD_SEG_NIBBLES = 'h50;

    // Stream layout: all pixels row-major, then the icons
    localparam int PIXEL_COUNT = X_PIXELS * Y_PIXELS;
    localparam int ITEM_COUNT  = PIXEL_COUNT + ICON_COUNT;
    localparam int ITEM_W      = $clog2(ITEM_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
    } state_e;

    // Location of one nibble: which segment, which nibble inside it
    typedef struct packed {
        logic       seg;
        logic [6:0] nibble;
    } seg_addr_t;

    // True when a CPU address page/nibble pair falls inside a segment window
    function automatic logic addr_in_range(input logic [3:0] page, input logic [6:0] nibble);
        return (page == LCD_LOWER_BASE[11:8]) && (nibble < 7'(LCD_SEG_NIBBLES));
    endfunction

endpackage

// File: rtl/lcd_segment_ram.sv
// Two 80-nibble display segments with two independent ports.
// Port A belongs to the CPU, port B to the scanout engine. Reads are
// registered and return the contents from before any same-edge write.
module lcd_segment_ram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_a_en,
    input  logic       i_a_we,
    input  seg_addr_t  i_a_addr,
    input  logic [3:0] i_a_wdata,
    output logic [3:0] o_a_rdata,
    input  logic       i_b_en,
    input  logic       i_b_we,
    input  seg_addr_t  i_b_addr,
    input  logic [3:0] i_b_wdata,
    output logic [3:0] o_b_rdata
);

    logic [3:0] r_mem [0:1][0:LCD_SEG_NIBBLES-1];
    logic [3:0] r_a_rdata;
    logic [3:0] r_b_rdata;

    // Storage writes; port A is written last so it wins an address collision
    // NOTE: the array has no reset so it maps onto RAM macros; only the read registers are reset.
    always_ff @(posedge clk) begin
        if (i_b_we) begin
            r_mem[i_b_addr.seg][i_b_addr.nibble] <= i_b_wdata;
        end
        if (i_a_we) begin
            r_mem[i_a_addr.seg][i_a_addr.nibble] <= i_a_wdata;
        end
    end

    // Registered reads; a disabled port holds its last value
    // NOTE: non-blocking assignment samples the array before this edge's write, giving old-data reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (i_a_en) begin
                r_a_rdata <= r_mem[i_a_addr.seg][i_a_addr.nibble];
            end
            if (i_b_en) begin
                r_b_rdata <= r_mem[i_b_addr.seg][i_b_addr.nibble];
            end
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/lcd_segment_scanout.sv
// CPU-side owner of the LCD segment RAM and its frame reader.
// The CPU writes nibbles through the bus port; on frame_start the block
// streams 512 pixels (row-major) and then 8 icons over a valid/ready link.
module lcd_segment_scanout
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] bus_addr,
    input  logic        bus_write_en,
    input  logic [3:0]  bus_write_data,
    output logic [3:0]  bus_read_data,
    input  logic        lcd_display_on,
    input  logic        lcd_all_on,
    input  logic        frame_start,
    output logic        busy,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [4:0]  pixel_x,
    output logic [3:0]  pixel_y,
    output logic        pixel_is_icon,
    output logic        pixel_on,
    output logic        frame_done
);

    // ------------------------------------------------------------------
    // CPU bus decode
    // ------------------------------------------------------------------
    logic       w_bus_in_range;
    logic       w_a_we;
    logic       w_a_en;
    seg_addr_t  w_a_addr;
    logic [3:0] w_a_rdata;
    logic       r_rd_valid;

    assign w_bus_in_range = addr_in_range(bus_addr[11:8], bus_addr[6:0]);
    assign w_a_addr       = '{seg: (bus_addr[7] == LCD_UPPER_BASE[7]), nibble: bus_addr[6:0]};
    assign w_a_we         = bus_write_en & w_bus_in_range;
    assign w_a_en         = w_bus_in_range & ~bus_write_en;

    // Remember whether last cycle was an in-range read; otherwise the bus sees 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_a_en;
        end
    end

    assign bus_read_data = r_rd_valid ? w_a_rdata : 4'h0;

    // ------------------------------------------------------------------
    // Scanout item counter and frame mode latches
    // ------------------------------------------------------------------
    state_e            r_state;
    state_e            w_next_state;
    logic [ITEM_W-1:0] r_item;
    logic              r_disp_on;
    logic              r_all_on;
    logic              w_is_icon;
    logic              w_last_item;
    logic              w_accept;
    logic              w_start;

    assign w_is_icon   = (r_item >= ITEM_W'(PIXEL_COUNT));
    assign w_last_item = (r_item == ITEM_W'(ITEM_COUNT - 1));
    assign w_accept    = (r_state == PRESENT) && pixel_ready;
    assign w_start     = (r_state == IDLE) && frame_start;

    // Item r_item maps to y = r_item[8:5], x = r_item[4:0] for pixels,
    // and icon index r_item[2:0] once past the last pixel.
    seg_addr_t  w_b_addr;
    logic [1:0] w_bit_sel;
    logic [3:0] w_b_rdata;
    logic       w_ram_bit;

    // Port B address and bit select for the item currently being fetched
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_b_addr  = '{seg: 1'b0, nibble: 7'h00};
        w_bit_sel = 2'd0;
        if (w_is_icon) begin
            w_b_addr.nibble = ICON_BASE + {4'b0000, r_item[2:0]};
        end else begin
            // nibble = 2*x + y[2], segment = y[3], bit = y[1:0]
            w_b_addr.seg    = r_item[8];
            w_b_addr.nibble = {1'b0, r_item[4:0], r_item[7]};
            w_bit_sel       = r_item[6:5];
        end
    end

    assign w_ram_bit = w_b_rdata[w_bit_sel];

    // Item counter advances on each accepted item; mode bits latch at frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_item    <= '0;
            r_disp_on <= 1'b0;
            r_all_on  <= 1'b0;
        end else begin
            if (w_start) begin
                r_item    <= '0;
                r_disp_on <= lcd_display_on;
                r_all_on  <= lcd_all_on;
            end else if (w_accept) begin
                r_item <= w_last_item ? '0 : r_item + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scanout FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fetch one cycle, present until accepted
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (frame_start) w_next_state = FETCH;
            FETCH:   w_next_state = PRESENT;
            PRESENT: if (pixel_ready) w_next_state = w_last_item ? DONE : FETCH;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from state; item fields come from the held counter and RAM word
    always_comb begin
        pixel_valid   = (r_state == PRESENT);
        busy          = (r_state != IDLE);
        frame_done    = (r_state == DONE);
        pixel_is_icon = (r_state == PRESENT) && w_is_icon;
        pixel_on      = (r_state == PRESENT) && (r_all_on || (r_disp_on && w_ram_bit));
        pixel_x       = w_is_icon ? {2'b00, r_item[2:0]} : r_item[4:0];
        pixel_y       = w_is_icon ? 4'd0 : r_item[8:5];
    end

    // ------------------------------------------------------------------
    // Segment RAM; port B reads only in FETCH so the word holds through PRESENT
    // ------------------------------------------------------------------
    lcd_segment_ram u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_a_en    (w_a_en),
        .i_a_we    (w_a_we),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (bus_write_data),
        .o_a_rdata (w_a_rdata),
        .i_b_en    (r_state == FETCH),
        .i_b_we    (1'b0),
        .i_b_addr  (w_b_addr),
        .i_b_wdata (4'h0),
        .o_b_rdata (w_b_rdata)
    );

endmodule

// File: tb/tb_lcd_segment_scanout.sv
// Directed bench for lcd_segment_scanout: bus table plus frame sequences.
module tb_lcd_segment_scanout;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] bus_addr;
    logic        bus_write_en;
    logic [3:0]  bus_write_data;
    logic [3:0]  bus_read_data;
    logic        lcd_display_on;
    logic        lcd_all_on;
    logic        frame_start;
    logic        busy;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [4:0]  pixel_x;
    logic [3:0]  pixel_y;
    logic        pixel_is_icon;
    logic        pixel_on;
    logic        frame_done;

    int passed = 0;
    int total  = 0;

    // Bench-side copy of the segment RAM
    logic [3:0] model [0:1][0:79];

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [3:0]  wdata;
        logic [3:0]  exp_rd;
        string       name;
    } bus_vec_t;

    bus_vec_t vecs [14];

    lcd_segment_scanout dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus_addr       (bus_addr),
        .bus_write_en   (bus_write_en),
        .bus_write_data (bus_write_data),
        .bus_read_data  (bus_read_data),
        .lcd_display_on (lcd_display_on),
        .lcd_all_on     (lcd_all_on),
        .frame_start    (frame_start),
        .busy           (busy),
        .pixel_valid    (pixel_valid),
        .pixel_ready    (pixel_ready),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .pixel_is_icon  (pixel_is_icon),
        .pixel_on       (pixel_on),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_write(input logic [11:0] addr, input logic [3:0] data);
        if (addr[11:8] == 4'hE && addr[6:0] < 7'h50)
            model[addr[7]][addr[6:0]] = data;
    endfunction

    // One-cycle CPU write, driven on the falling edge
    task automatic bus_write(input logic [11:0] addr, input logic [3:0] data);
        bus_addr       = addr;
        bus_write_data = data;
        bus_write_en   = 1'b1;
        model_write(addr, data);
        @(negedge clk);
        bus_write_en   = 1'b0;
    endtask

    // Expected item k of a frame given the latched modes
    task automatic exp_item(input int k, input bit disp, input bit all,
                            output int ex, output int ey, output bit eicon, output bit eon);
        int seg, n, b;
        bit ram;
        if (k < 512) begin
            ey    = k / 32;
            ex    = k % 32;
            seg   = ey / 8;
            n     = 2 * ex + ((ey % 8) / 4);
            b     = ey % 4;
            ram   = model[seg][n][b];
            eicon = 1'b0;
        end else begin
            ex    = k - 512;
            ey    = 0;
            ram   = model[0][64 + ex][0];
            eicon = 1'b1;
        end
        eon = all | (disp & ram);
    endtask

    // Stream one full frame and check order, contents, stability and completion
    task automatic run_frame(input string tag, input bit disp, input bit all,
                             input bit rand_ready, input bit toggle_modes,
                             input bit restart_mid, input int exp_lit);
        int idx = 0, errs = 0, stab_errs = 0, done_cnt = 0, lit = 0, cyc;
        int ex, ey;
        bit eicon, eon, r, hold = 1'b0, first = 1'b1, timed_out = 1'b1;
        logic [4:0] hx;
        logic [3:0] hy;
        logic hi, ho;
        lcd_display_on = disp;
        lcd_all_on     = all;
        pixel_ready    = 1'b1;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check({tag, "_valid_lat1"}, pixel_valid, 0);
        check({tag, "_busy_start"}, busy, 1);
        for (cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (first) begin
                check({tag, "_valid_lat2"}, pixel_valid, 1);
                first = 1'b0;
            end
            if (frame_done) done_cnt++;
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            if (hold) begin
                if (pixel_valid !== 1'b1 || pixel_x !== hx || pixel_y !== hy ||
                    pixel_is_icon !== hi || pixel_on !== ho)
                    stab_errs++;
                hold = 1'b0;
            end
            if (toggle_modes && idx >= 100) begin
                lcd_display_on = ~disp;
                lcd_all_on     = ~all;
            end
            frame_start = (restart_mid && idx == 50);
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            pixel_ready = r;
            if (pixel_valid) begin
                if (r) begin
                    exp_item(idx, disp, all, ex, ey, eicon, eon);
                    if (pixel_x !== 5'(ex) || pixel_y !== 4'(ey) ||
                        pixel_is_icon !== eicon || pixel_on !== eon) begin
                        if (errs < 5)
                            $display("  item %0d: x=%0d y=%0d icon=%0b on=%0b want x=%0d y=%0d icon=%0b on=%0b",
                                     idx, pixel_x, pixel_y, pixel_is_icon, pixel_on, ex, ey, eicon, eon);
                        errs++;
                    end
                    if (pixel_on) lit++;
                    idx++;
                end else begin
                    hold = 1'b1;
                    hx = pixel_x; hy = pixel_y; hi = pixel_is_icon; ho = pixel_on;
                end
            end
        end
        frame_start = 1'b0;
        pixel_ready = 1'b1;
        check({tag, "_timeout"}, timed_out, 0);
        check({tag, "_items"}, idx, 520);
        check({tag, "_item_errs"}, errs, 0);
        check({tag, "_lit"}, lit, exp_lit);
        check({tag, "_done_pulses"}, done_cnt, 1);
        if (rand_ready) check({tag, "_stable_errs"}, stab_errs, 0);
        if (restart_mid) begin
            repeat (3) @(negedge clk);
            check({tag, "_no_restart"}, busy, 0);
        end
    endtask

    initial begin
        int done_seen;
        reset_n        = 1'b0;
        bus_addr       = '0;
        bus_write_en   = 1'b0;
        bus_write_data = '0;
        lcd_display_on = 1'b0;
        lcd_all_on     = 1'b0;
        frame_start    = 1'b0;
        pixel_ready    = 1'b0;

        vecs[0]  = '{1'b1, 12'hE00, 4'h5, 4'h0, "wr_e00"};
        vecs[1]  = '{1'b0, 12'hE00, 4'h0, 4'h5, "rd_e00"};
        vecs[2]  = '{1'b0, 12'hE50, 4'h0, 4'h0, "rd_e50"};
        vecs[3]  = '{1'b0, 12'hF00, 4'h0, 4'h0, "rd_f00"};
        vecs[4]  = '{1'b1, 12'hECF, 4'hA, 4'h0, "wr_ecf"};
        vecs[5]  = '{1'b0, 12'hECF, 4'h0, 4'hA, "rd_ecf"};
        vecs[6]  = '{1'b1, 12'hE4F, 4'h3, 4'h0, "wr_e4f"};
        vecs[7]  = '{1'b0, 12'hE4F, 4'h0, 4'h3, "rd_e4f"};
        vecs[8]  = '{1'b0, 12'hED0, 4'h0, 4'h0, "rd_ed0"};
        vecs[9]  = '{1'b1, 12'hE80, 4'hC, 4'h0, "wr_e80"};
        vecs[10] = '{1'b0, 12'hE80, 4'h0, 4'hC, "rd_e80"};
        vecs[11] = '{1'b0, 12'hE00, 4'h0, 4'h5, "rd_e00_again"};
        vecs[12] = '{1'b0, 12'h600, 4'h0, 4'h0, "rd_600"};
        vecs[13] = '{1'b0, 12'hECF, 4'h0, 4'hA, "rd_ecf_again"};

        repeat (2) @(negedge clk);
        check("rst_valid", pixel_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_rdata", bus_read_data, 0);
        check("rst_on", pixel_on, 0);
        check("rst_xy", {pixel_x, pixel_y, pixel_is_icon}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Bus table: each vector occupies one cycle, read data checked next cycle
        for (int i = 0; i < 14; i++) begin
            bus_addr       = vecs[i].addr;
            bus_write_en   = vecs[i].we;
            bus_write_data = vecs[i].wdata;
            if (vecs[i].we) model_write(vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            bus_write_en = 1'b0;
            check(vecs[i].name, bus_read_data, vecs[i].exp_rd);
        end

        // Clear both segments, then plant two pixels and two icons
        for (int s = 0; s < 2; s++)
            for (int n = 0; n < 80; n++)
                bus_write(12'hE00 | 12'(s << 7) | 12'(n), 4'h0);
        bus_write(12'hE00, 4'h1);
        bus_write(12'hE81, 4'h8);
        bus_write(12'hE40, 4'h1);
        bus_write(12'hE47, 4'h1);

        run_frame("basic", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        run_frame("randrdy", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        run_frame("dispoff", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        run_frame("allon", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 520);

        // Upper nibble 0x0F lights x=7, y=12..15
        bus_write(12'hE8F, 4'hF);
        run_frame("column", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8);

        // Reset in the middle of a frame
        lcd_display_on = 1'b1;
        pixel_ready    = 1'b1;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", pixel_valid, 0);
        check("midrst_busy", busy, 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done) done_seen++;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (frame_done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        check("midrst_idle", busy, 0);

        // RAM survives the reset
        run_frame("postrst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
